oversample_filter: RTL

//  Boxcar-averages 2^os consecutive ADC samples and emits one signed mean per window.

---
 rtl/oversample_filter_pkg.sv | 16 +
 rtl/oversample_filter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/oversample_filter_pkg.sv
// Shared types and helpers for the oversampling boxcar filter.
// Pure declarations: no latency, no flow control.
// Backpressure: not applicable.
package oversample_filter_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } upd_state_t;

  // Index of the final sample in a window of 2^os samples.
  function automatic int unsigned win_last_idx(input int unsigned os);
    return (32'd1 << os) - 32'd1;
  endfunction

endpackage

// File: rtl/oversample_filter.sv
// Averages 2^os consecutive signed samples, one mean strobe per completed window.
// Latency: mean strobes two edges after the final sample is presented.
// Backpressure: none; accepts a sample every cycle, sustains one output per cycle.
module oversample_filter
  import oversample_filter_pkg::*;
#(
  parameter int W_IN    = 16,
  parameter int W_OUT   = 18,
  parameter int OS_W    = 3,
  parameter int OS_INIT = 0
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic [W_IN-1:0]  data_in,
  input  logic             data_valid_in,
  input  logic [OS_W-1:0]  os_in,
  input  logic             update_en_in,
  input  logic             update_in,
  input  logic             clear_in,
  output logic [W_OUT-1:0] data_out,
  output logic             data_valid_out
);

  localparam int MAX_OS = 2**OS_W - 1;
  localparam int W_ACC  = W_IN + MAX_OS;

  if (W_OUT < W_IN) begin : g_bad_width
    $error("oversample_filter: W_OUT must be >= W_IN");
  end

  logic signed [W_ACC-1:0] acc;
  logic signed [W_ACC-1:0] sum_s1;
  logic signed [W_ACC-1:0] data_ext;
  logic signed [W_ACC-1:0] mean_s1;
  logic [MAX_OS-1:0]       cnt;
  logic [OS_W-1:0]         os_act;
  logic [OS_W-1:0]         os_pend;
  logic [OS_W-1:0]         os_s1;
  logic                    s1_valid;
  upd_state_t              state;

  logic last_smp;
  logic sample;
  logic upd;
  logic apply;

  assign data_ext = {{MAX_OS{data_in[W_IN-1]}}, data_in};
  assign last_smp = (cnt == MAX_OS'(win_last_idx(32'(os_act))));
  assign sample   = data_valid_in && !clear_in;
  assign upd      = update_in && update_en_in;
  // Ratio may only switch on a window boundary so windows never mix ratios.
  assign apply    = data_valid_in ? last_smp : (cnt == '0);
  assign mean_s1  = sum_s1 >>> os_s1;

  // Accumulator and first pipeline stage.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      acc      <= '0;
      cnt      <= '0;
      sum_s1   <= '0;
      os_s1    <= OS_W'(OS_INIT);
      s1_valid <= 1'b0;
    end else if (clear_in) begin
      acc      <= '0;
      cnt      <= '0;
      s1_valid <= 1'b0;
    end else if (sample) begin
      if (last_smp) begin
        sum_s1   <= acc + data_ext;
        os_s1    <= os_act;
        s1_valid <= 1'b1;
        acc      <= '0;
        cnt      <= '0;
      end else begin
        acc      <= acc + data_ext;
        cnt      <= cnt + 1'b1;
        s1_valid <= 1'b0;
      end
    end else begin
      s1_valid <= 1'b0;
    end
  end

  // Output stage: data_out holds between strobes and across a clear.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      data_out       <= '0;
      data_valid_out <= 1'b0;
    end else if (clear_in) begin
      data_valid_out <= 1'b0;
    end else begin
      data_valid_out <= s1_valid;
      if (s1_valid) begin
        data_out <= W_OUT'(mean_s1);
      end
    end
  end

  // Ratio update FSM; a newer request while pending replaces the older one.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state   <= ST_RUN;
      os_act  <= OS_W'(OS_INIT);
      os_pend <= OS_W'(OS_INIT);
    end else if (!clear_in) begin
      case (state)
        ST_RUN: begin
          if (upd) begin
            os_pend <= os_in;
            state   <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (upd) begin
            os_pend <= os_in;
          end else if (apply) begin
            os_act <= os_pend;
            state  <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule
